// File: rtl/ysyx_041461_lsu.sv
// Load/store unit for the MEM stage: issues one doubleword bus access per
// memory op, lane-shifts store data, extends load data and reports traps.
// Optional feature: define YSYX_041461_LSU_MISALIGN_CHECK_EN to trap
// misaligned H/W/D accesses instead of issuing them.
module ysyx_041461_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_in,
  input  logic [3:0]  lsu_MEM_ctrl_in,
  input  logic [63:0] lsu_addr_in,
  input  logic [63:0] lsu_wdata_in,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_wen,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wmask,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_rdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic [1:0]  lsu_trap
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LD = 4'd4,
    OP_LBU = 4'd5, OP_LHU = 4'd6, OP_LWU = 4'd7,
    OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10, OP_SD = 4'd11
  } op_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [2:0]    off_q;
  logic [CW-1:0] cnt;

  logic          in_load;
  logic          in_store;
  logic          accept;
  logic          misaligned;
  logic          timeout;
  logic [1:0]    in_size;
  logic [7:0]    in_mask;
  logic [63:0]   shifted;
  logic [63:0]   ld_data;

  // Decode the incoming op: class, access size and byte strobes.
  always_comb begin
    in_load  = (lsu_MEM_ctrl_in >= OP_LB) && (lsu_MEM_ctrl_in <= OP_LWU);
    in_store = (lsu_MEM_ctrl_in >= OP_SB) && (lsu_MEM_ctrl_in <= OP_SD);
    in_size  = 2'd0;
    case (lsu_MEM_ctrl_in)
      OP_LH, OP_LHU, OP_SH: in_size = 2'd1;
      OP_LW, OP_LWU, OP_SW: in_size = 2'd2;
      OP_LD, OP_SD:         in_size = 2'd3;
      default:              in_size = 2'd0;
    endcase
    case (in_size)
      2'd0:    in_mask = 8'h01;
      2'd1:    in_mask = 8'h03;
      2'd2:    in_mask = 8'h0F;
      default: in_mask = 8'hFF;
    endcase
    in_mask = in_mask << lsu_addr_in[2:0];
`ifdef YSYX_041461_LSU_MISALIGN_CHECK_EN
    case (in_size)
      2'd1:    misaligned = lsu_addr_in[0];
      2'd2:    misaligned = |lsu_addr_in[1:0];
      2'd3:    misaligned = |lsu_addr_in[2:0];
      default: misaligned = 1'b0;
    endcase
`else
    misaligned = 1'b0;
`endif
    accept  = (state == S_IDLE) && lsu_valid_in && (in_load || in_store);
    timeout = (cnt >= CW'(TIMEOUT_CYCLES - 1));
  end

  // Stall while an access is outstanding or being accepted; reset forces it low.
  always_comb begin
    lsu_stall = rst && ((state == S_REQ) || (state == S_WAIT) || accept);
  end

  // Align the response to the latched byte offset and extend per latched op.
  always_comb begin
    shifted = bus_rsp_rdata >> {off_q, 3'b000};
    case (op_q)
      OP_LB:   ld_data = {{56{shifted[7]}}, shifted[7:0]};
      OP_LH:   ld_data = {{48{shifted[15]}}, shifted[15:0]};
      OP_LW:   ld_data = {{32{shifted[31]}}, shifted[31:0]};
      OP_LD:   ld_data = shifted;
      OP_LBU:  ld_data = {56'd0, shifted[7:0]};
      OP_LHU:  ld_data = {48'd0, shifted[15:0]};
      OP_LWU:  ld_data = {32'd0, shifted[31:0]};
      default: ld_data = '0;
    endcase
  end

  // Access FSM with registered bus and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      op_q          <= '0;
      off_q         <= '0;
      cnt           <= '0;
      bus_req_valid <= 1'b0;
      bus_req_wen   <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wmask <= '0;
      lsu_done      <= 1'b0;
      lsu_rdata     <= '0;
      lsu_trap      <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          lsu_done <= 1'b0;
          if (accept) begin
            op_q          <= lsu_MEM_ctrl_in;
            off_q         <= lsu_addr_in[2:0];
            cnt           <= '0;
            bus_req_addr  <= {lsu_addr_in[63:3], 3'b000};
            bus_req_wen   <= in_store;
            bus_req_wdata <= in_store ? (lsu_wdata_in << {lsu_addr_in[2:0], 3'b000}) : '0;
            bus_req_wmask <= in_store ? in_mask : '0;
            if (misaligned) begin
              state     <= S_DONE;
              lsu_done  <= 1'b1;
              lsu_trap  <= 2'd1;
              lsu_rdata <= '0;
            end else begin
              state         <= S_REQ;
              bus_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          cnt <= cnt + CW'(1);
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= S_WAIT;
          end else if (timeout) begin
            bus_req_valid <= 1'b0;
            state         <= S_DONE;
            lsu_done      <= 1'b1;
            lsu_trap      <= 2'd2;
            lsu_rdata     <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (bus_rsp_valid) begin
            state     <= S_DONE;
            lsu_done  <= 1'b1;
            lsu_trap  <= 2'd0;
            lsu_rdata <= bus_req_wen ? '0 : ld_data;
          end else if (timeout) begin
            state     <= S_DONE;
            lsu_done  <= 1'b1;
            lsu_trap  <= 2'd2;
            lsu_rdata <= '0;
          end
        end
        default: begin
          lsu_done <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_lsu.sv
// Directed bench for ysyx_041461_lsu: main instance with the default timeout
// and a second instance with TIMEOUT_CYCLES=4 for the access-fault path.
module tb_ysyx_041461_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, to_valid;
  logic [3:0]  ctrl;
  logic [63:0] addr, wdata;
  logic        ready, rsp, to_ready, to_rsp;
  logic [63:0] rdata_in;

  logic        req_valid, req_wen, stall, done;
  logic [63:0] req_addr, req_wdata, rdata;
  logic [7:0]  req_wmask;
  logic [1:0]  trap;

  logic        to_req_valid, to_req_wen, to_stall, to_done;
  logic [63:0] to_req_addr, to_req_wdata, to_rdata;
  logic [7:0]  to_req_wmask;
  logic [1:0]  to_trap;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ysyx_041461_lsu dut (
    .clk(clk), .rst(rst), .lsu_valid_in(valid), .lsu_MEM_ctrl_in(ctrl),
    .lsu_addr_in(addr), .lsu_wdata_in(wdata),
    .bus_req_valid(req_valid), .bus_req_ready(ready), .bus_req_wen(req_wen),
    .bus_req_addr(req_addr), .bus_req_wdata(req_wdata), .bus_req_wmask(req_wmask),
    .bus_rsp_valid(rsp), .bus_rsp_rdata(rdata_in),
    .lsu_stall(stall), .lsu_done(done), .lsu_rdata(rdata), .lsu_trap(trap)
  );

  ysyx_041461_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .lsu_valid_in(to_valid), .lsu_MEM_ctrl_in(ctrl),
    .lsu_addr_in(addr), .lsu_wdata_in(wdata),
    .bus_req_valid(to_req_valid), .bus_req_ready(to_ready), .bus_req_wen(to_req_wen),
    .bus_req_addr(to_req_addr), .bus_req_wdata(to_req_wdata), .bus_req_wmask(to_req_wmask),
    .bus_rsp_valid(to_rsp), .bus_rsp_rdata(rdata_in),
    .lsu_stall(to_stall), .lsu_done(to_done), .lsu_rdata(to_rdata), .lsu_trap(to_trap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b1; to_valid = 1'b0; ctrl = 4'd3;
    addr = 64'h8000_0004; wdata = '0; ready = 1'b0; rsp = 1'b0;
    to_ready = 1'b0; to_rsp = 1'b0; rdata_in = '0;

    // Reset: all outputs zero, stall overridden despite a pending load
    nx(); nx(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_trap", trap, 0);
    chk("rst_bus", {req_wen, req_wmask, req_addr | req_wdata}, 0);
    valid = 1'b0; ctrl = 4'd0; rst = 1'b1;
    nx();

    // NOP and undefined op codes pass through
    valid = 1'b1; ctrl = 4'd0; #1;
    chk("nop_stall", stall, 0);
    ctrl = 4'd12; #1;
    chk("op12_stall", stall, 0);
    nx();
    chk("nop_req_valid", req_valid, 0);
    chk("nop_done", done, 0);

    // LW at 0x80000004, sign-extended upper word
    ctrl = 4'd3; addr = 64'h8000_0004; #1;
    chk("lw_accept_stall", stall, 1);
    nx();
    valid = 1'b0; ctrl = 4'd0;
    chk("lw_req_valid", req_valid, 1);
    chk("lw_req_addr", req_addr, 64'h8000_0000);
    chk("lw_req_wen_mask", {req_wen, req_wmask}, 0);
    chk("lw_req_stall", stall, 1);
    ready = 1'b1;
    nx();
    ready = 1'b0;
    chk("lw_wait_req_valid", req_valid, 0);
    chk("lw_wait_stall", stall, 1);
    chk("lw_wait_done", done, 0);
    rsp = 1'b1; rdata_in = 64'h8000_0000_0000_0000;
    nx();
    rsp = 1'b0;
    chk("lw_done", done, 1);
    chk("lw_rdata", rdata, 64'hFFFF_FFFF_8000_0000);
    chk("lw_trap", trap, 0);
    chk("lw_done_stall", stall, 0);
    nx();
    chk("lw_done_pulse", done, 0);

    // SB at 0x80000003, ready delayed three cycles
    valid = 1'b1; ctrl = 4'd8; addr = 64'h8000_0003; wdata = 64'hAB;
    nx();
    valid = 1'b0; ctrl = 4'd0; wdata = '0;
    chk("sb_wmask", req_wmask, 8'h08);
    chk("sb_wdata", req_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_wen", req_wen, 1);
    for (int i = 0; i < 4; i++) begin
      chk("sb_req_held", req_valid, 1);
      chk("sb_stall", stall, 1);
      ready = (i == 3);
      nx();
    end
    ready = 1'b0;
    chk("sb_wait_req_valid", req_valid, 0);
    chk("sb_wait_stall", stall, 1);
    rsp = 1'b1;
    nx();
    rsp = 1'b0;
    chk("sb_done", done, 1);
    chk("sb_rdata", rdata, 0);
    chk("sb_trap", trap, 0);
    nx();

    // SH at 0x80000001 (misaligned halfword)
    valid = 1'b1; ctrl = 4'd9; addr = 64'h8000_0001; wdata = 64'h1234;
    nx();
    valid = 1'b0; ctrl = 4'd0;
`ifdef YSYX_041461_LSU_MISALIGN_CHECK_EN
    chk("sh_mis_req_valid", req_valid, 0);
    chk("sh_mis_done", done, 1);
    chk("sh_mis_trap", trap, 1);
    nx();
`else
    chk("sh_req_valid", req_valid, 1);
    chk("sh_wmask", req_wmask, 8'h06);
    chk("sh_wdata", req_wdata, 64'h0000_0000_0012_3400);
    ready = 1'b1;
    nx();
    ready = 1'b0; rsp = 1'b1;
    nx();
    rsp = 1'b0;
    chk("sh_done", done, 1);
    chk("sh_trap", trap, 0);
    nx();
`endif

    // LBU at 0x80000007, then a back-to-back LH offered during DONE
    valid = 1'b1; ctrl = 4'd5; addr = 64'h8000_0007;
    nx();
    valid = 1'b0; ctrl = 4'd0; ready = 1'b1;
    nx();
    ready = 1'b0; rsp = 1'b1; rdata_in = 64'hFF00_0000_0000_0000;
    nx();
    rsp = 1'b0;
    chk("lbu_done", done, 1);
    chk("lbu_rdata", rdata, 64'hFF);
    valid = 1'b1; ctrl = 4'd2; addr = 64'h8000_0002; #1;
    chk("b2b_done_stall", stall, 0);
    nx();
    chk("b2b_not_in_done", req_valid, 0);
    chk("b2b_idle_done", done, 0);
    chk("b2b_idle_stall", stall, 1);
    nx();
    valid = 1'b0; ctrl = 4'd0;
    chk("lh_req_valid", req_valid, 1);
    chk("lh_req_addr", req_addr, 64'h8000_0000);
    ready = 1'b1;
    nx();
    ready = 1'b0; rsp = 1'b1; rdata_in = 64'h0000_0000_8001_0000;
    nx();
    rsp = 1'b0;
    chk("lh_done", done, 1);
    chk("lh_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
    nx();

    // LD never answered on the TIMEOUT_CYCLES=4 instance
    to_valid = 1'b1; ctrl = 4'd4; addr = 64'h8000_0008;
    nx();
    to_valid = 1'b0; ctrl = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("to_pending_done", to_done, 0);
      chk("to_pending_req", to_req_valid, 1);
      nx();
    end
    chk("to_done", to_done, 1);
    chk("to_trap", to_trap, 2);
    chk("to_rdata", to_rdata, 0);
    nx();

    // Reset during WAIT, then a stray response
    valid = 1'b1; ctrl = 4'd4; addr = 64'h8000_0010;
    nx();
    valid = 1'b0; ctrl = 4'd0; ready = 1'b1;
    nx();
    ready = 1'b0;
    chk("rw_wait_stall", stall, 1);
    rst = 1'b0; #1;
    chk("rw_async_stall", stall, 0);
    chk("rw_async_addr", req_addr, 0);
    nx();
    rst = 1'b1; rsp = 1'b1; rdata_in = 64'h1234;
    nx();
    rsp = 1'b0;
    chk("rw_no_done", done, 0);
    chk("rw_rdata", rdata, 0);
    chk("rw_trap", trap, 0);
    chk("rw_stall", stall, 0);
    chk("rw_bus", {req_valid, req_wen, req_wmask, req_addr | req_wdata}, 0);
    nx();
    chk("rw_no_done_later", done, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
